// File: rtl/fifo_rd_drain_if.sv
// Handshake bundle between the FIFO read side, the drain block and the downstream stream.
interface fifo_rd_drain_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] data_out;
    logic             rd_req;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [CNT_W-1:0] word_cnt;
    logic             busy;

    modport master (
        input  en, fifo_empty, data_out, m_ready,
        output rd_req, m_valid, m_data, word_cnt, busy
    );

    modport slave (
        output en, fifo_empty, data_out, m_ready,
        input  rd_req, m_valid, m_data, word_cnt, busy
    );
endinterface

// File: rtl/fifo_rd_drain.sv
// Async-FIFO read-side drain: credit-based read issue, 2-entry skid buffer,
// delivered-word counter and an IDLE/ACTIVE/DRAINING activity FSM.
module fifo_rd_drain #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            r_clk,
    input  logic            rrst,
    fifo_rd_drain_if.master bus
);
    localparam int unsigned OCC_W  = 2;
    localparam int unsigned CRED_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        DRAINING = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               infl_q;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               pop_c;
    logic               rd_req_c;
    logic [CRED_W-1:0]  credit_c;

    // Credit check: entries held after this cycle must leave room for the new read.
    always_comb begin
        pop_c    = valid_q && bus.m_ready;
        credit_c = CRED_W'(occ_q) + CRED_W'(infl_q) - CRED_W'(pop_c);
        rd_req_c = !rrst && bus.en && !bus.fifo_empty && (credit_c < CRED_W'(2));
    end

    // Skid buffer and counter next state; head is always the oldest word.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pop_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case ({infl_q, pop_c})
            2'b10: begin
                if (occ_q == OCC_W'(0)) begin
                    head_d = bus.data_out;
                    occ_d  = OCC_W'(1);
                end else begin
                    tail_d = bus.data_out;
                    occ_d  = OCC_W'(2);
                end
            end
            2'b01: begin
                if (occ_q == OCC_W'(2)) begin
                    head_d = tail_q;
                end
                occ_d = occ_q - OCC_W'(1);
            end
            2'b11: begin
                if (occ_q == OCC_W'(2)) begin
                    head_d = tail_q;
                    tail_d = bus.data_out;
                end else begin
                    head_d = bus.data_out;
                end
            end
            default: ;
        endcase
        valid_d = (occ_d != OCC_W'(0));
    end

    // Activity FSM; leaving DRAINING looks at the post-update occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!bus.en) begin
                    state_d = ((occ_q != OCC_W'(0)) || infl_q) ? DRAINING : IDLE;
                end
            end
            DRAINING: begin
                if (bus.en) begin
                    state_d = ACTIVE;
                end else if ((occ_d == OCC_W'(0)) && !rd_req_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge r_clk) begin
        if (rrst) begin
            state_q <= IDLE;
            occ_q   <= '0;
            infl_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            infl_q  <= rd_req_c;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.rd_req   = rd_req_c;
    assign bus.m_valid  = valid_q;
    assign bus.m_data   = head_q;
    assign bus.word_cnt = cnt_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: queue-based FIFO model feeding the DUT and a scoreboard on the stream side.
module tb_fifo_rd_drain;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic r_clk;
    logic rrst;

    fifo_rd_drain_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fifo_rd_drain #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .r_clk (r_clk),
        .rrst  (rrst),
        .bus   (bus)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock: monitor at negedge, FIFO read-side model at posedge, return 1 time unit later.
    task automatic tick();
        logic        rd_fire;
        logic [31:0] e;
        @(negedge r_clk);
        rd_fire = (bus.rd_req === 1'b1);
        if (rd_fire) chk("rd_req_while_empty", 32'(bus.fifo_empty), 32'd0);
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
            chk("m_data_order", bus.m_data, e);
        end
        @(posedge r_clk);
        if (rrst) begin
            fifo_q.delete();
            exp_q.delete();
            bus.data_out <= '0;
        end else if (rd_fire && fifo_q.size() != 0) begin
            bus.data_out <= fifo_q.pop_front();
        end else begin
            bus.data_out <= 32'hDEAD_BEEF;
        end
        bus.fifo_empty <= (fifo_q.size() == 0);
        #1;
    endtask

    initial begin
        bus.fifo_empty <= 1'b1;
        bus.data_out   <= '0;
        bus.en      = 1'b1;
        bus.m_ready = 1'b0;
        rrst        = 1'b1;
        tick();
        tick();
        // Reset values
        chk("rst_m_valid",  32'(bus.m_valid),  32'd0);
        chk("rst_m_data",   bus.m_data,        32'd0);
        chk("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_rd_req",   32'(bus.rd_req),   32'd0);

        // Basic drain: 1..8, latency and back-to-back output
        rrst = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        tick();
        chk("basic_first_rd_req", 32'(bus.rd_req), 32'd1);
        tick();
        chk("basic_valid_n1", 32'(bus.m_valid), 32'd0);
        tick();
        chk("basic_valid_n2", 32'(bus.m_valid), 32'd1);
        chk("basic_first_data", bus.m_data, 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("basic_back_to_back", 32'(bus.m_valid), 32'd1);
        end
        tick();
        chk("basic_valid_end", 32'(bus.m_valid), 32'd0);
        chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("basic_word_cnt", 32'(bus.word_cnt), 32'd8);

        // Backpressure: A0..A3 held off for 10 cycles
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 4) begin
                chk("bp_rd_req",  32'(bus.rd_req),  32'd0);
                chk("bp_m_valid", 32'(bus.m_valid), 32'd1);
                chk("bp_m_data",  bus.m_data,       32'hA0);
            end
        end
        chk("bp_occ_full", 32'(dut.occ_q), 32'd2);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("bp_word_cnt", 32'(bus.word_cnt), 32'd12);

        // Alternating ready: 16 words, no loss or duplication
        for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            bus.m_ready = ~bus.m_ready;
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        tick();
        chk("alt_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("alt_m_valid",  32'(bus.m_valid),  32'd0);
        chk("alt_word_cnt", 32'(bus.word_cnt), 32'd12);

        // Enable drop right after a read
        bus.en = 1'b0;
        tick();
        tick();
        chk("drop_pre_idle", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) push_word(32'h200 + 32'(i));
        tick();
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        tick();
        chk("drop_state_draining", 32'(dut.state_q), 32'd2);
        chk("drop_busy_draining",  32'(bus.busy),    32'd1);
        chk("drop_rd_req",         32'(bus.rd_req),  32'd0);
        chk("drop_inflight_data",  bus.m_data,       32'h200);
        tick();
        chk("drop_state_idle", 32'(dut.state_q), 32'd0);
        chk("drop_busy_idle",  32'(bus.busy),    32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop_no_rd_req", 32'(bus.rd_req), 32'd0);
        end
        chk("drop_fifo_left", 32'(fifo_q.size()), 32'd3);
        chk("drop_word_cnt",  32'(bus.word_cnt),  32'd13);

        // Reset mid-stream with the skid buffer full
        bus.m_ready = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_occ_full", 32'(dut.occ_q), 32'd2);
        rrst = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        chk("mid_rd_req_gated", 32'(bus.rd_req), 32'd0);
        tick();
        chk("mid_m_valid",  32'(bus.m_valid),  32'd0);
        chk("mid_m_data",   bus.m_data,        32'd0);
        chk("mid_word_cnt", 32'(bus.word_cnt), 32'd0);
        chk("mid_busy",     32'(bus.busy),     32'd0);
        chk("mid_rd_req",   32'(bus.rd_req),   32'd0);

        // Counter wrap with a 4-bit counter: 17 words -> 1
        rrst = 1'b0;
        for (int i = 0; i < 17; i++) push_word(32'h300 + 32'(i));
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
        tick();
        chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("wrap_word_cnt", 32'(bus.word_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
